// File: rtl/reg_bank8_writer_pkg.sv
// Shared definitions for the 8-entry register bank write side.
package reg_bank8_writer_pkg;

  localparam int unsigned WIDTH_DEF = 10;
  localparam int unsigned NREG      = 8;
  localparam int unsigned SEL_W     = 3;

  // Encoding 2'd3 is unused and decodes as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank8_writer_dec3to8.sv
// 3-bit select plus enable to 8-bit one-hot write strobe.
module reg_bank8_writer_dec3to8
  import reg_bank8_writer_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [NREG-1:0]  strobe_c
);

  // One-hot decode, all zero when disabled.
  always_comb begin
    strobe_c      = '0;
    if (en) begin
      strobe_c[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank8_writer.sv
// Write side of the 8-entry register bank: single writes by select and an
// auto-incrementing 8-word burst load behind a valid/ready handshake.
module reg_bank8_writer
  import reg_bank8_writer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_burst,
  input  logic             burst_abort,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [NREG-1:0]  written,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nx;
  logic [SEL_W-1:0] ptr, ptr_nx;
  logic [SEL_W-1:0] cnt, cnt_nx;
  logic             done_nx;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [NREG-1:0]  strobe;
  logic             xfer;
  logic [WIDTH-1:0] regs [NREG];

  assign xfer = in_valid & in_ready;

  reg_bank8_writer_dec3to8 u_dec (
    .sel      (wr_sel),
    .en       (wr_en),
    .strobe_c (strobe)
  );

  // State, counters and the registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      cnt      <= cnt_nx;
      done     <= done_nx;
      busy     <= (state_nx != ST_IDLE);
      in_ready <= (state_nx != ST_DONE);
    end
  end

  // Next-state, pointer/count update and write steering.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    wr_en    = 1'b0;
    wr_sel   = ptr;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          wr_en  = 1'b1;
          wr_sel = in_sel;
          if (in_burst) begin
            ptr_nx   = in_sel + 3'd1;
            cnt_nx   = 3'd1;
            state_nx = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (xfer) begin
          wr_en  = 1'b1;
          wr_sel = ptr;
          ptr_nx = ptr + 3'd1;
          cnt_nx = cnt + 3'd1;
        end
        // The eighth word completing takes priority over an abort.
        if (xfer && (cnt == 3'd7)) begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
        end else if (burst_abort) begin
          state_nx = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Holding registers: only the strobed entry loads; others hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NREG); k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NREG); k++) begin
        if (strobe[k]) begin
          regs[k] <= in_data;
        end
      end
    end
  end

  // Written flags: a write in the same cycle as a clear keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written <= '0;
    end else begin
      written <= (clear_flags ? '0 : written) | strobe;
    end
  end

  assign q0 = regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
  assign q4 = regs[4];
  assign q5 = regs[5];
  assign q6 = regs[6];
  assign q7 = regs[7];

endmodule

// File: tb/tb_reg_bank8_writer.sv
// Directed self-checking bench for reg_bank8_writer.
module tb_reg_bank8_writer;

  localparam int unsigned W = 10;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_sel;
  logic         in_burst;
  logic         burst_abort;
  logic         clear_flags;
  logic [W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]   written;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fails;
  logic [W-1:0] exp_q [8];

  reg_bank8_writer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_burst    (in_burst),
    .burst_abort (burst_abort),
    .clear_flags (clear_flags),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .q4          (q4),
    .q5          (q5),
    .q6          (q6),
    .q7          (q7),
    .written     (written),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_q(input string tag);
    logic [W-1:0] act [8];
    act = '{q0, q1, q2, q3, q4, q5, q6, q7};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s q%0d", tag, k), 32'(act[k]), 32'(exp_q[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_sel      = '0;
    in_burst    = 1'b0;
    burst_abort = 1'b0;
    clear_flags = 1'b0;
    for (int k = 0; k < 8; k++) exp_q[k] = '0;

    // 1: async reset asserted mid-cycle takes effect immediately
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_q("reset");
    chk("reset written", 32'(written), 32'h00);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    #3;
    rst = 1'b0;
    tick();

    // 2: single writes, old value visible during the transfer cycle
    in_valid = 1'b1; in_sel = 3'd3; in_data = 10'h155;
    chk("single q3 before edge", 32'(q3), 32'h000);
    tick();
    exp_q[3] = 10'h155;
    chk("single q3 after edge", 32'(q3), 32'h155);
    in_sel = 3'd7; in_data = 10'h2AA;
    tick();
    exp_q[7] = 10'h2AA;
    in_valid = 1'b0; in_sel = 3'd1; in_data = 10'h3FF;
    tick();
    tick();
    chk_q("single");
    chk("single written", 32'(written), 32'h88);
    chk("single busy", 32'(busy), 32'd0);

    // 3: burst starting at 5 wraps 5,6,7,0,1,2,3,4
    in_valid = 1'b1; in_burst = 1'b1; in_sel = 3'd5; in_data = 10'd1;
    tick();
    chk("burst busy", 32'(busy), 32'd1);
    chk("burst in_ready", 32'(in_ready), 32'd1);
    in_burst = 1'b0; in_sel = 3'd0;
    for (int i = 2; i <= 8; i++) begin
      in_data = W'(i);
      tick();
      if (i < 8) chk($sformatf("burst no early done w%0d", i), 32'(done), 32'd0);
    end
    chk("burst done pulse", 32'(done), 32'd1);
    chk("burst in_ready low in DONE", 32'(in_ready), 32'd0);
    chk("burst busy in DONE", 32'(busy), 32'd1);
    exp_q[5] = 10'd1; exp_q[6] = 10'd2; exp_q[7] = 10'd3; exp_q[0] = 10'd4;
    exp_q[1] = 10'd5; exp_q[2] = 10'd6; exp_q[3] = 10'd7; exp_q[4] = 10'd8;
    chk("burst written", 32'(written), 32'hFF);
    // valid held through DONE must not be accepted
    in_data = 10'h3FF; in_sel = 3'd1;
    tick();
    in_valid = 1'b0;
    chk("post done cleared", 32'(done), 32'd0);
    chk("post done busy", 32'(busy), 32'd0);
    chk("post done in_ready", 32'(in_ready), 32'd1);
    chk_q("burst");

    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("clear written", 32'(written), 32'h00);

    // 4: burst with gaps, then abort after 3 words
    in_valid = 1'b1; in_burst = 1'b1; in_sel = 3'd0; in_data = 10'h011;
    tick();
    in_burst = 1'b0; in_valid = 1'b0; in_sel = 3'd6;
    tick();
    chk("gap q1 held", 32'(q1), 32'd5);
    chk("gap busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_data = 10'h022;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 10'h033;
    tick();
    in_valid = 1'b0; burst_abort = 1'b1;
    tick();
    burst_abort = 1'b0;
    exp_q[0] = 10'h011; exp_q[1] = 10'h022; exp_q[2] = 10'h033;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort written", 32'(written), 32'h07);
    chk_q("abort");

    // abort with a simultaneous transfer still writes that word
    in_valid = 1'b1; in_burst = 1'b1; in_sel = 3'd6; in_data = 10'h066;
    tick();
    in_burst = 1'b0; in_data = 10'h077; burst_abort = 1'b1;
    tick();
    in_valid = 1'b0; burst_abort = 1'b0;
    exp_q[6] = 10'h066; exp_q[7] = 10'h077;
    chk("abort+xfer busy", 32'(busy), 32'd0);
    chk("abort+xfer written", 32'(written), 32'hC7);
    chk_q("abort+xfer");

    // 5: clear and write to reg 2 in the same cycle
    clear_flags = 1'b1; in_valid = 1'b1; in_sel = 3'd2; in_data = 10'h02C;
    tick();
    clear_flags = 1'b0; in_valid = 1'b0;
    exp_q[2] = 10'h02C;
    chk("race written", 32'(written), 32'h04);
    chk("race q2", 32'(q2), 32'h02C);

    // 6: reset after four burst words
    in_valid = 1'b1; in_burst = 1'b1; in_sel = 3'd4;
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(10'h100 + i);
      tick();
      in_burst = 1'b0;
    end
    chk("midburst busy", 32'(busy), 32'd1);
    chk("midburst q7", 32'(q7), 32'h104);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) exp_q[k] = '0;
    chk_q("midburst reset");
    chk("midburst reset busy", 32'(busy), 32'd0);
    chk("midburst reset in_ready", 32'(in_ready), 32'd1);
    chk("midburst reset written", 32'(written), 32'h00);
    #3;
    rst = 1'b0;
    tick();
    tick();
    chk("midburst no done", 32'(done), 32'd0);
    in_valid = 1'b1; in_sel = 3'd1; in_data = 10'h3C1;
    tick();
    in_valid = 1'b0;
    exp_q[1] = 10'h3C1;
    tick();
    chk_q("after reset");
    chk("after reset written", 32'(written), 32'h02);
    chk("after reset busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
